serial_alu_seq: RTL and testbench

//  Bit-serial sequencer around the 1-bit ALU (top_alu, instanced inside).
//  - Accepts WIDTH-bit operands, an op code and an initial carry/borrow.
//  - Feeds top_alu LSB-first, one bit per clock, and registers CB_out back into CB_in.
//  - Collects Result bits into a WIDTH-bit word.
//  - Is the multi-bit front end between register/IO logic and the 1-bit ALU.

---
 rtl/serial_alu_seq_pkg.sv | 26 ++
 rtl/serial_alu_seq_top_alu.sv | 47 ++++
 rtl/serial_alu_seq.sv | 163 ++++++++++++++++
 tb/tb_serial_alu_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_seq_pkg.sv
// serial_alu_seq_pkg
//   Shared constants for the bit-serial ALU sequencer and its 1-bit ALU.
//   - ALU op codes (AND, OR, XOR, ADD, SUB); other codes are inert.
//   - Sequencer state encoding (IDLE, RUN, DONE).
//   - alu_op_is_arith: marks the ops whose carry/borrow chain is meaningful.
`timescale 1ns/1ps
package serial_alu_seq_pkg;

  localparam logic [2:0] ALU_OP_AND = 3'b000;
  localparam logic [2:0] ALU_OP_OR  = 3'b001;
  localparam logic [2:0] ALU_OP_XOR = 3'b010;
  localparam logic [2:0] ALU_OP_ADD = 3'b011;
  localparam logic [2:0] ALU_OP_SUB = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Logic ops report CB_out=0; only ADD/SUB propagate a chain.
  function automatic logic alu_op_is_arith(input logic [2:0] op);
    return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
  endfunction

endpackage

// File: rtl/serial_alu_seq_top_alu.sv
// top_alu
//   1-bit ALU slice used by the serial sequencer.
// Ports
//   In1, In2  in  1  operand bits
//   CB_in     in  1  carry (ADD) or borrow (SUB) into this bit
//   code_op   in  3  op code from serial_alu_seq_pkg
//   Result    out 1  result bit
//   CB_out    out 1  carry/borrow out; 0 for logic ops and unused codes
`timescale 1ns/1ps
module top_alu
  import serial_alu_seq_pkg::*;
(
  input  logic       In1,
  input  logic       In2,
  input  logic       CB_in,
  input  logic [2:0] code_op,
  output logic       Result,
  output logic       CB_out
);

  logic w_p;
  assign w_p = In1 ^ In2;

  always_comb begin
    Result = 1'b0;
    CB_out = 1'b0;
    case (code_op)
      ALU_OP_AND: Result = In1 & In2;
      ALU_OP_OR:  Result = In1 | In2;
      ALU_OP_XOR: Result = w_p;
      ALU_OP_ADD: begin
        Result = w_p ^ CB_in;
        CB_out = (In1 & In2) | (CB_in & w_p);
      end
      ALU_OP_SUB: begin
        // In1 - In2 - borrow: borrow out when In2 (plus borrow) exceeds In1.
        Result = w_p ^ CB_in;
        CB_out = (~In1 & In2) | (CB_in & ~w_p);
      end
      default: begin
        Result = 1'b0;
        CB_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// serial_alu_seq
//   Bit-serial front end for the 1-bit top_alu. Operands are latched on an
//   accepted start, fed LSB-first one bit per clock with the carry/borrow
//   registered back into the ALU, and the result bits are assembled into a
//   WIDTH-bit word.
// Handshake
//   start is a level request sampled only in IDLE; while RUN or DONE it is
//   ignored (not queued). done is a one-cycle pulse in DONE; result, cb_out
//   (and zero) are valid from that cycle and held until the next DONE.
//   One operation takes WIDTH+2 cycles start-to-start.
// Ports
//   clk, rst_n            clock (rising), async active-low reset
//   start                 request
//   op[2:0]               ALU op code, latched at accept
//   a, b [WIDTH-1:0]      operands, latched at accept
//   cb_init               carry/borrow into bit 0
//   busy                  high in RUN
//   done                  one-cycle pulse in DONE
//   result [WIDTH-1:0]    assembled result
//   cb_out                carry/borrow out of the MSB
//   zero                  result==0 (only with SERIAL_ALU_ZERO_FLAG_EN)
//   dbg_state [1:0]       current FSM state (state_e encoding)
// Configuration
//   SERIAL_ALU_ZERO_FLAG_EN: adds the zero output and its accumulator.
`timescale 1ns/1ps
module serial_alu_seq
  import serial_alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cb_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cb_out,
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_op;
  logic             r_cb;
  logic             r_cb_out;
  logic [CW-1:0]    r_cnt;
  logic             w_alu_res;
  logic             w_alu_cb;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  top_alu u_alu (
    .In1     (r_a_sh[0]),
    .In2     (r_b_sh[0]),
    .CB_in   (r_cb),
    .code_op (r_op),
    .Result  (w_alu_res),
    .CB_out  (w_alu_cb)
  );

  assign w_last    = (r_cnt == CNT_LAST);
  assign w_res_nxt = {w_alu_res, r_res_sh[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand shifters, carry loop, result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_result <= '0;
      r_op     <= '0;
      r_cb     <= 1'b0;
      r_cb_out <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_op   <= op;
            r_cb   <= cb_init;
            r_cnt  <= '0;
          end
        end
        ST_RUN: begin
          r_res_sh <= w_res_nxt;
          r_cb     <= w_alu_cb;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          if (w_last) begin
            // Load visible outputs on the edge into DONE so they only
            // change there. The counter holds rather than wrapping.
            r_result <= w_res_nxt;
            r_cb_out <= w_alu_cb;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic r_zero_acc;
  logic r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero_acc <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_zero_acc <= 1'b1;
      end else if (r_state == ST_RUN) begin
        r_zero_acc <= r_zero_acc & ~w_alu_res;
        if (w_last) r_zero <= r_zero_acc & ~w_alu_res;
      end
    end
  end

  assign zero = r_zero;
`endif

  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign result    = r_result;
  assign cb_out    = r_cb_out;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq
//   Scoreboard bench for serial_alu_seq (WIDTH=8). Expected words come from a
//   word-level model of the ALU ops; results are popped when done pulses.
`timescale 1ns/1ps
module tb_serial_alu_seq;
  import serial_alu_seq_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #0.5 clk = ~clk;

  logic         start = 1'b0;
  logic [2:0]   op_i = '0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         cb_i = 1'b0;
  logic         busy, done, cb_out;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic         zero;
`endif

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op_i),
    .a         (a_i),
    .b         (b_i),
    .cb_init   (cb_i),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cb_out    (cb_out),
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    .zero      (zero),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];   // {cb_out, result}
  logic       zexp_q[$];
  logic [W:0] last_exp;
  int n_total = 0;
  int n_bad = 0;
  int done_count = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Word-level reference: returns {carry/borrow out, result}.
  function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                       input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    case (o)
      ALU_OP_AND: t = {1'b0, x & y};
      ALU_OP_OR:  t = {1'b0, x | y};
      ALU_OP_XOR: t = {1'b0, x ^ y};
      ALU_OP_ADD: t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      ALU_OP_SUB: t = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
      default:    t = '0;
    endcase
    return t;
  endfunction

  task automatic push_exp(input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic c);
    last_exp = model(o, x, y, c);
    exp_q.push_back(last_exp);
    zexp_q.push_back(last_exp[W-1:0] == '0);
  endtask

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    logic [W:0] e;
    logic       ez;
    if (rst_n && done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        chk_val("spurious_done", 32'(1), 32'(0));
      end else begin
        e  = exp_q.pop_front();
        ez = zexp_q.pop_front();
        chk_val("result", 32'(result), 32'(e[W-1:0]));
        chk_val("cb_out", 32'(cb_out), 32'(e[W]));
        chk_val("busy_in_done", 32'(busy), 32'(0));
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        chk_val("zero", 32'(zero), 32'(ez));
`else
        if (ez === 1'bx) chk_val("zero_model", 32'(ez), 32'(0));
`endif
      end
    end
  end

  // ---------------- driver tasks (call at a negedge) ----------------
  task automatic start_op(input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic c);
    int guard = 0;
    while (dbg_state != 2'd0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk_val("idle_wait", 32'(guard < 40), 32'(1));
    op_i = o; a_i = x; b_i = y; cb_i = c; start = 1'b1;
    @(posedge clk);
    push_exp(o, x, y, c);
    @(negedge clk);
    start = 1'b0;
    chk_val("busy_run", 32'(busy), 32'(1));
  endtask

  // n = index of the negedge after the accept edge at which done is seen.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk_val("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic run_check(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic c);
    int n;
    start_op(o, x, y, c);
    wait_done(n);
    chk_val({tag, "_latency"}, 32'(n), 32'(W + 1));
    @(negedge clk);
    chk_val({tag, "_done_pulse"}, 32'(done), 32'(0));
    chk_val({tag, "_hold"}, 32'({cb_out, result}), 32'(last_exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int dc0;
    int t_done[$];

    repeat (3) @(negedge clk);
    chk_val("rst_busy", 32'(busy), 32'(0));
    chk_val("rst_done", 32'(done), 32'(0));
    chk_val("rst_result", 32'(result), 32'(0));
    chk_val("rst_cb_out", 32'(cb_out), 32'(0));
    chk_val("rst_state", 32'(dbg_state), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_check("add_5a_33", ALU_OP_ADD, 8'h5A, 8'h33, 1'b0);
    run_check("add_ff_01", ALU_OP_ADD, 8'hFF, 8'h01, 1'b0);
    run_check("sub_10_01", ALU_OP_SUB, 8'h10, 8'h01, 1'b0);
    run_check("sub_borrow", ALU_OP_SUB, 8'h01, 8'h02, 1'b1);
    run_check("and", ALU_OP_AND, 8'hF0, 8'h3C, 1'b1);
    run_check("or", ALU_OP_OR, 8'hA0, 8'h05, 1'b0);
    run_check("xor", ALU_OP_XOR, 8'hAA, 8'hFF, 1'b0);

    // start re-pulsed during RUN and operand changed mid-run
    dc0 = done_count;
    start_op(ALU_OP_ADD, 8'h12, 8'h34, 1'b1);
    @(negedge clk);
    a_i = 8'hFF; b_i = 8'h00; op_i = ALU_OP_XOR; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(n);
    repeat (12) @(negedge clk);
    chk_val("midrun_one_done", 32'(done_count - dc0), 32'(1));
    chk_val("midrun_q_empty", 32'(exp_q.size()), 32'(0));

    // Reset in run cycle 4 aborts without done
    dc0 = done_count;
    start_op(ALU_OP_ADD, 8'h77, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    zexp_q.delete();
    #0.2;
    chk_val("abort_busy", 32'(busy), 32'(0));
    chk_val("abort_result", 32'(result), 32'(0));
    chk_val("abort_cb_out", 32'(cb_out), 32'(0));
    chk_val("abort_state", 32'(dbg_state), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk_val("abort_no_done", 32'(done_count - dc0), 32'(0));
    run_check("after_abort", ALU_OP_SUB, 8'h80, 8'h7F, 1'b0);

    // Random operations
    for (int i = 0; i < 8; i++) begin
      run_check("rand", 3'($urandom_range(0, 4)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    // start held for 30 cycles: back-to-back runs WIDTH+2 apart
    op_i = ALU_OP_ADD; a_i = 8'h3C; b_i = 8'h4D; cb_i = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      if (i % (W + 2) == 0) push_exp(ALU_OP_ADD, 8'h3C, 8'h4D, 1'b1);
      @(negedge clk);
      if (done) t_done.push_back(i);
    end
    start = 1'b0;
    chk_val("held_done_cnt", 32'(t_done.size()), 32'(3));
    if (t_done.size() == 3) begin
      chk_val("held_gap1", 32'(t_done[1] - t_done[0]), 32'(W + 2));
      chk_val("held_gap2", 32'(t_done[2] - t_done[1]), 32'(W + 2));
    end
    repeat (14) @(negedge clk);
    chk_val("final_q_empty", 32'(exp_q.size()), 32'(0));
    chk_val("final_idle", 32'(dbg_state), 32'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global time limit
  initial begin
    #5000;
    n_bad++;
    $display("FAIL global_timeout got=running exp=finished");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule
